lcd_receiver: RTL and testbench
===============================

LCD_RECEIVER -- requirements
Module: lcd_receiver

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth applied to all LCD input pins (minimum 2).
REQ-002 CLK_1M  input  1  sole clock; samples the LCD bus.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 LCD_E  input  1  LCD enable strobe; a transfer latches on its falling edge.
REQ-005 LCD_RS  input  1  1 = data transfer, 0 = instruction.
REQ-006 LCD_RW  input  1  1 = read, 0 = write.
REQ-007 LCD_DATA  input  8  LCD bus byte.
REQ-008 RD_ADDR  input  5  shadow-screen read index: 0-15 is line 1, 16-31 is line 2.
REQ-009 RD_CHAR  output  8  registered shadow character at RD_ADDR.
REQ-010 CMD_VALID  output  1  one-cycle pulse per accepted write transfer.
REQ-011 CMD_CODE  output  3  class of the transfer, valid while CMD_VALID is high.
REQ-012 INIT_DONE  output  1  high once the init sequence has completed.
REQ-013 CURSOR  output  7  current DDRAM address counter.
REQ-014 ERR  output  1  sticky protocol-error flag.

Function
REQ-015 Input synchronization: LCD_E, LCD_RS, LCD_RW and LCD_DATA shall pass through identical SYNC_STAGES-deep chains. A strobe is defined as the synchronized E being 1 in the previous cycle and 0 in the current cycle. RS, RW and DATA shall be taken from the last synchronized sample in which E was 1.
REQ-016 Strobes with RW=1 shall be ignored: no CMD_VALID pulse and no state change.
REQ-017 Latency: CMD_VALID and CMD_CODE shall assert exactly 1 CLK_1M cycle after the strobe cycle.
REQ-018 CMD_CODE encoding, by RS and the highest set data bit:
- 0 = data write (RS=1)
- 1 = clear (0x01)
- 2 = home (0x02-0x03)
- 3 = entry mode (0x04-0x07)
- 4 = display control (0x08-0x0F)
- 5 = shift (0x10-0x1F)
- 6 = function set (0x20-0x3F)
- 7 = CGRAM/DDRAM address set (0x40-0xFF)
REQ-019 Init FSM states: INIT_IDLE, INIT_FS, INIT_DO, INIT_EM, READY.
- INIT_IDLE --0x3C--> INIT_FS.
- INIT_FS: 0x3C stays; 0x0C goes to INIT_DO.
- INIT_DO: 0x0C stays; 0x06 goes to INIT_EM.
- INIT_EM: 0x06 stays; any data write, or any command other than 0x06, goes to READY and is then processed as a READY transfer.
- Any other instruction in INIT_IDLE, INIT_FS or INIT_DO returns to INIT_IDLE.
REQ-020 INIT_DONE shall be high exactly in READY and in the CLEARING sub-state.
REQ-021 Data write before READY: ERR shall be set; the shadow and CURSOR are unchanged; CMD_VALID still pulses.
REQ-022 Data write in READY: store DATA at CURSOR 0x00-0x0F to index CURSOR, and at 0x40-0x4F to index 16+(CURSOR-0x40). Writes to 0x10-0x27 or 0x50-0x67 are off-screen: not stored, no error.
REQ-023 After every data write, CURSOR shall step by ID (1 = increment, 0 = decrement) with these wraps:
- 0x27+1 -> 0x40
- 0x67+1 -> 0x00
- 0x00-1 -> 0x67
- 0x40-1 -> 0x27
REQ-024 Clear (READY only): enter CLEARING and write 0x20 to indices 0-31, one per cycle (32 cycles). Then set CURSOR=0x00, ID=1, and return to READY.
REQ-025 Any strobe during CLEARING shall set ERR and be dropped, with no CMD_VALID pulse.
REQ-026 Home: CURSOR=0x00. Entry mode: ID=DATA[1].
REQ-027 The following shall only pulse CMD_VALID: display control, shift, function set, and CGRAM set (0x40-0x7F).
REQ-028 DDRAM set (0x80-0xFF): CURSOR=DATA[6:0] if it lies in 0x00-0x27 or 0x40-0x67; otherwise set ERR and leave CURSOR unchanged.
REQ-029 RD_CHAR shall equal shadow[RD_ADDR] one cycle after RD_ADDR is applied. A write and a read of the same index in one cycle shall return the old value.
REQ-030 ERR shall clear only on RESET.

Reset
REQ-031 While RESET is high, and until the first clock edge after its release:
- init FSM = INIT_IDLE, INIT_DONE=0
- CURSOR=0x00, ID=1, ERR=0
- CMD_VALID=0, CMD_CODE=0
- RD_CHAR=0x20, all shadow entries = 0x20
- synchronizer chains = 0
REQ-032 Assertion of RESET at any time, including mid-CLEARING or mid-strobe, shall abort immediately. A falling edge of E already inside the synchronizer at release shall not produce a strobe.

Verification
REQ-033 Send 30x 0x3C, 30x 0x0C, 30x 0x06, then data 0x41 (E at 1 kHz) -> INIT_DONE=1; RD_ADDR=0 reads 0x41; CURSOR=0x01; CMD_CODE sequence 6, 4, 3, 0; ERR=0.
REQ-034 In READY, send 0xC0 then data 0x42 -> RD_ADDR=16 reads 0x42; CURSOR=0x41.
REQ-035 In READY, send 0xA7 then two data bytes -> first byte is not stored; CURSOR goes 0x27, 0x40, 0x41; second byte appears at index 16.
REQ-036 Send data 0x30 before init -> ERR=1; all shadow entries remain 0x20; INIT_DONE=0.
REQ-037 After filling line 1, send 0x01 -> indices 0-31 read 0x20 within 33 CLK_1M cycles; CURSOR=0x00. A strobe forced during CLEARING -> ERR=1.
REQ-038 Send 0x04 then three data bytes starting from CURSOR=0x00 -> bytes land at the indices mapped from 0x00, 0x67 (off-screen) and 0x66 (off-screen); CURSOR ends at 0x65.

Source files
------------

// File: rtl/lcd_receiver_if.sv
// Bus bundle for lcd_receiver: LCD pins and shadow read index in, status and read data out.
interface lcd_receiver_if;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic [7:0] LCD_DATA;
    logic [4:0] RD_ADDR;
    logic [7:0] RD_CHAR;
    logic       CMD_VALID;
    logic [2:0] CMD_CODE;
    logic       INIT_DONE;
    logic [6:0] CURSOR;
    logic       ERR;

    // Bench / host side: drives the LCD pins and read index, observes status.
    modport master (
        output LCD_E, LCD_RS, LCD_RW, LCD_DATA, RD_ADDR,
        input  RD_CHAR, CMD_VALID, CMD_CODE, INIT_DONE, CURSOR, ERR
    );

    // Receiver side.
    modport slave (
        input  LCD_E, LCD_RS, LCD_RW, LCD_DATA, RD_ADDR,
        output RD_CHAR, CMD_VALID, CMD_CODE, INIT_DONE, CURSOR, ERR
    );
endinterface

// File: rtl/lcd_receiver.sv
// Passive HD44780-style bus snooper: synchronizes the LCD pins, decodes write
// transfers on the falling edge of E, tracks the init sequence and keeps a
// 2x16 shadow of the visible screen.
module lcd_receiver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic          CLK_1M,
    input  logic          RESET,
    lcd_receiver_if.slave bus
);

    typedef enum logic [2:0] {
        INIT_IDLE,
        INIT_FS,
        INIT_DO,
        INIT_EM,
        READY,
        CLEARING
    } state_t;

    logic [SYNC_STAGES-1:0]      r_e_sync;
    logic [SYNC_STAGES-1:0]      r_rs_sync;
    logic [SYNC_STAGES-1:0]      r_rw_sync;
    logic [SYNC_STAGES-1:0][7:0] r_data_sync;
    logic                        w_e;
    logic                        w_rs;
    logic                        w_rw;
    logic [7:0]                  w_data;

    logic                        r_e_prev;
    logic                        r_cap_rs;
    logic                        r_cap_rw;
    logic [7:0]                  r_cap_data;
    logic                        w_strobe;
    logic [2:0]                  w_code;

    state_t                      r_state;
    state_t                      w_state_nx;
    logic [6:0]                  r_cursor;
    logic [6:0]                  w_cursor_nx;
    logic [6:0]                  w_cursor_step;
    logic                        r_id;
    logic                        w_id_nx;
    logic                        r_err;
    logic                        w_err_nx;
    logic                        r_cmd_valid;
    logic                        w_cmd_valid_nx;
    logic [2:0]                  r_cmd_code;
    logic [2:0]                  w_cmd_code_nx;
    logic [4:0]                  r_clr_cnt;
    logic [4:0]                  w_clr_cnt_nx;
    logic                        w_proc_ready;
    logic                        w_ddram_ok;

    logic                        w_wr_en;
    logic [4:0]                  w_wr_idx;
    logic [7:0]                  w_wr_data;
    logic [31:0][7:0]            r_shadow;
    logic [7:0]                  r_rd_char;

    assign w_e    = r_e_sync[SYNC_STAGES-1];
    assign w_rs   = r_rs_sync[SYNC_STAGES-1];
    assign w_rw   = r_rw_sync[SYNC_STAGES-1];
    assign w_data = r_data_sync[SYNC_STAGES-1];

    assign w_strobe = r_e_prev & ~w_e;

    // Identical synchronizer chains for every LCD input pin.
    always_ff @(posedge CLK_1M or posedge RESET) begin
        if (RESET) begin
            r_e_sync    <= '0;
            r_rs_sync   <= '0;
            r_rw_sync   <= '0;
            r_data_sync <= '0;
        end else begin
            r_e_sync    <= {r_e_sync[SYNC_STAGES-2:0], bus.LCD_E};
            r_rs_sync   <= {r_rs_sync[SYNC_STAGES-2:0], bus.LCD_RS};
            r_rw_sync   <= {r_rw_sync[SYNC_STAGES-2:0], bus.LCD_RW};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], bus.LCD_DATA};
        end
    end

    // Edge history of E and capture of RS/RW/DATA while E is still high.
    always_ff @(posedge CLK_1M or posedge RESET) begin
        if (RESET) begin
            r_e_prev   <= 1'b0;
            r_cap_rs   <= 1'b0;
            r_cap_rw   <= 1'b0;
            r_cap_data <= '0;
        end else begin
            r_e_prev <= w_e;
            if (w_e) begin
                r_cap_rs   <= w_rs;
                r_cap_rw   <= w_rw;
                r_cap_data <= w_data;
            end
        end
    end

    // Transfer class from RS and the highest set data bit.
    always_comb begin
        w_code = 3'd0;
        if (r_cap_rs)                     w_code = 3'd0;
        else if (r_cap_data[7:6] != 2'b00) w_code = 3'd7;
        else if (r_cap_data[5])           w_code = 3'd6;
        else if (r_cap_data[4])           w_code = 3'd5;
        else if (r_cap_data[3])           w_code = 3'd4;
        else if (r_cap_data[2])           w_code = 3'd3;
        else if (r_cap_data[1])           w_code = 3'd2;
        else if (r_cap_data[0])           w_code = 3'd1;
    end

    // Cursor step with the DDRAM line wraps, and DDRAM-set address validity.
    always_comb begin
        w_cursor_step = r_cursor;
        if (r_id) begin
            if (r_cursor == 7'h27)      w_cursor_step = 7'h40;
            else if (r_cursor == 7'h67) w_cursor_step = 7'h00;
            else                        w_cursor_step = r_cursor + 7'd1;
        end else begin
            if (r_cursor == 7'h00)      w_cursor_step = 7'h67;
            else if (r_cursor == 7'h40) w_cursor_step = 7'h27;
            else                        w_cursor_step = r_cursor - 7'd1;
        end
        w_ddram_ok = (r_cap_data[6:0] <= 7'h27) ||
                     ((r_cap_data[6:0] >= 7'h40) && (r_cap_data[6:0] <= 7'h67));
    end

    // Next-state and datapath decisions for the init/command FSM.
    always_comb begin
        w_state_nx     = r_state;
        w_cursor_nx    = r_cursor;
        w_id_nx        = r_id;
        w_err_nx       = r_err;
        w_cmd_valid_nx = 1'b0;
        w_cmd_code_nx  = r_cmd_code;
        w_clr_cnt_nx   = r_clr_cnt;
        w_wr_en        = 1'b0;
        w_wr_idx       = '0;
        w_wr_data      = 8'h20;
        w_proc_ready   = 1'b0;

        if (r_state == CLEARING) begin
            w_wr_en      = 1'b1;
            w_wr_idx     = r_clr_cnt;
            w_clr_cnt_nx = r_clr_cnt + 5'd1;
            if (r_clr_cnt == 5'd31) begin
                w_state_nx  = READY;
                w_cursor_nx = 7'h00;
                w_id_nx     = 1'b1;
            end
            if (w_strobe && !r_cap_rw) begin
                w_err_nx = 1'b1;
            end
        end else if (w_strobe && !r_cap_rw) begin
            w_cmd_valid_nx = 1'b1;
            w_cmd_code_nx  = w_code;
            case (r_state)
                INIT_IDLE: begin
                    if (r_cap_rs)                  w_err_nx   = 1'b1;
                    else if (r_cap_data == 8'h3C)  w_state_nx = INIT_FS;
                    else                           w_state_nx = INIT_IDLE;
                end
                INIT_FS: begin
                    if (r_cap_rs)                  w_err_nx   = 1'b1;
                    else if (r_cap_data == 8'h3C)  w_state_nx = INIT_FS;
                    else if (r_cap_data == 8'h0C)  w_state_nx = INIT_DO;
                    else                           w_state_nx = INIT_IDLE;
                end
                INIT_DO: begin
                    if (r_cap_rs)                  w_err_nx   = 1'b1;
                    else if (r_cap_data == 8'h0C)  w_state_nx = INIT_DO;
                    else if (r_cap_data == 8'h06)  w_state_nx = INIT_EM;
                    else                           w_state_nx = INIT_IDLE;
                end
                INIT_EM: begin
                    // Anything but a repeated 0x06 completes init and is then
                    // handled exactly like a transfer arriving in READY.
                    if (!r_cap_rs && (r_cap_data == 8'h06)) begin
                        w_state_nx = INIT_EM;
                    end else begin
                        w_state_nx   = READY;
                        w_proc_ready = 1'b1;
                    end
                end
                READY:    w_proc_ready = 1'b1;
                default:  w_state_nx   = INIT_IDLE;
            endcase

            if (w_proc_ready) begin
                if (r_cap_rs) begin
                    w_wr_data = r_cap_data;
                    if (r_cursor[6:4] == 3'b000) begin
                        w_wr_en  = 1'b1;
                        w_wr_idx = {1'b0, r_cursor[3:0]};
                    end else if (r_cursor[6:4] == 3'b100) begin
                        w_wr_en  = 1'b1;
                        w_wr_idx = {1'b1, r_cursor[3:0]};
                    end
                    w_cursor_nx = w_cursor_step;
                end else begin
                    case (w_code)
                        3'd1: begin
                            w_state_nx   = CLEARING;
                            w_clr_cnt_nx = '0;
                        end
                        3'd2: w_cursor_nx = 7'h00;
                        3'd3: w_id_nx     = r_cap_data[1];
                        3'd7: begin
                            if (r_cap_data[7]) begin
                                if (w_ddram_ok) w_cursor_nx = r_cap_data[6:0];
                                else            w_err_nx    = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // FSM state and control registers.
    always_ff @(posedge CLK_1M or posedge RESET) begin
        if (RESET) begin
            r_state     <= INIT_IDLE;
            r_cursor    <= 7'h00;
            r_id        <= 1'b1;
            r_err       <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_cmd_code  <= 3'd0;
            r_clr_cnt   <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_cursor    <= w_cursor_nx;
            r_id        <= w_id_nx;
            r_err       <= w_err_nx;
            r_cmd_valid <= w_cmd_valid_nx;
            r_cmd_code  <= w_cmd_code_nx;
            r_clr_cnt   <= w_clr_cnt_nx;
        end
    end

    // Shadow screen storage and registered read port (read returns pre-write data).
    always_ff @(posedge CLK_1M or posedge RESET) begin
        if (RESET) begin
            r_shadow  <= {32{8'h20}};
            r_rd_char <= 8'h20;
        end else begin
            r_rd_char <= r_shadow[bus.RD_ADDR];
            if (w_wr_en) begin
                r_shadow[w_wr_idx] <= w_wr_data;
            end
        end
    end

    assign bus.RD_CHAR   = r_rd_char;
    assign bus.CMD_VALID = r_cmd_valid;
    assign bus.CMD_CODE  = r_cmd_code;
    assign bus.INIT_DONE = (r_state == READY) || (r_state == CLEARING);
    assign bus.CURSOR    = r_cursor;
    assign bus.ERR       = r_err;

endmodule

// File: tb/tb_lcd_receiver.sv
// Directed bench for lcd_receiver: command codes go through a scoreboard queue,
// screen contents and status are compared against hand-derived constants.
`timescale 1ns/1ps
module tb_lcd_receiver;

    logic CLK_1M = 1'b0;
    logic RESET;

    lcd_receiver_if bus ();

    lcd_receiver #(.SYNC_STAGES(2)) dut (
        .CLK_1M (CLK_1M),
        .RESET  (RESET),
        .bus    (bus)
    );

    always #500 CLK_1M = ~CLK_1M;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [2:0] exp_q [$];
    logic [2:0] mon_exp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Every CMD_VALID pulse must match the oldest expected code.
    always @(negedge CLK_1M) begin
        if (RESET === 1'b0 && bus.CMD_VALID === 1'b1) begin
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_errors++;
                $error("FAIL unexpected_cmd: observed pulse code %0d expected no pulse", bus.CMD_CODE);
            end
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                check("cmd_code", 32'(bus.CMD_CODE), 32'(mon_exp));
            end
        end
    end

    task automatic pulse_e(input logic rs, input logic rw, input logic [7:0] d, input int hi);
        @(negedge CLK_1M);
        bus.LCD_RS   = rs;
        bus.LCD_RW   = rw;
        bus.LCD_DATA = d;
        @(negedge CLK_1M);
        bus.LCD_E = 1'b1;
        repeat (hi) @(negedge CLK_1M);
        bus.LCD_E = 1'b0;
    endtask

    // Waits a bounded window after the E fall; a pulse must arrive on the 3rd negedge.
    task automatic expect_cmd(input bit expct, input logic [2:0] code, input string tag);
        int lat;
        lat = 0;
        if (expct) exp_q.push_back(code);
        for (int i = 1; i <= 8; i++) begin
            @(negedge CLK_1M);
            if (bus.CMD_VALID === 1'b1 && lat == 0) lat = i;
            if (lat != 0) break;
        end
        check({tag, "_lat"}, 32'(lat), expct ? 32'd3 : 32'd0);
    endtask

    task automatic wr(input logic rs, input logic [7:0] d, input logic [2:0] code);
        pulse_e(rs, 1'b0, d, 4);
        expect_cmd(1'b1, code, $sformatf("wr_%0d_%02h", rs, d));
        @(negedge CLK_1M);
    endtask

    task automatic rd_check(input logic [4:0] a, input logic [7:0] expv, input string tag);
        @(negedge CLK_1M);
        bus.RD_ADDR = a;
        @(negedge CLK_1M);
        check($sformatf("%s_rd%0d", tag, a), 32'(bus.RD_CHAR), 32'(expv));
    endtask

    task automatic do_reset();
        RESET     = 1'b1;
        bus.LCD_E = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge CLK_1M);
        RESET = 1'b0;
        repeat (2) @(negedge CLK_1M);
    endtask

    task automatic do_init();
        for (int i = 0; i < 30; i++) wr(1'b0, 8'h3C, 3'd6);
        for (int i = 0; i < 30; i++) wr(1'b0, 8'h0C, 3'd4);
        for (int i = 0; i < 30; i++) wr(1'b0, 8'h06, 3'd3);
    endtask

    initial begin
        #50_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET        = 1'b1;
        bus.LCD_E    = 1'b0;
        bus.LCD_RS   = 1'b0;
        bus.LCD_RW   = 1'b0;
        bus.LCD_DATA = 8'h00;
        bus.RD_ADDR  = 5'd0;
        repeat (3) @(negedge CLK_1M);

        // Values held while reset is asserted
        check("rst_init_done", 32'(bus.INIT_DONE), 32'd0);
        check("rst_cursor",    32'(bus.CURSOR),    32'h00);
        check("rst_err",       32'(bus.ERR),       32'd0);
        check("rst_cmd_valid", 32'(bus.CMD_VALID), 32'd0);
        check("rst_cmd_code",  32'(bus.CMD_CODE),  32'd0);
        check("rst_rd_char",   32'(bus.RD_CHAR),   32'h20);
        RESET = 1'b0;
        repeat (2) @(negedge CLK_1M);

        // Data write before init
        wr(1'b1, 8'h30, 3'd0);
        check("early_err",       32'(bus.ERR),       32'd1);
        check("early_init_done", 32'(bus.INIT_DONE), 32'd0);
        check("early_cursor",    32'(bus.CURSOR),    32'h00);
        for (int i = 0; i < 32; i++) rd_check(5'(i), 8'h20, "early");

        // Reset landing on the E falling edge must not yield a strobe
        do_reset();
        check("rst_clears_err", 32'(bus.ERR), 32'd0);
        @(negedge CLK_1M);
        bus.LCD_RS   = 1'b1;
        bus.LCD_RW   = 1'b0;
        bus.LCD_DATA = 8'h30;
        @(negedge CLK_1M);
        bus.LCD_E = 1'b1;
        repeat (4) @(negedge CLK_1M);
        bus.LCD_E = 1'b0;
        RESET     = 1'b1;
        @(negedge CLK_1M);
        RESET = 1'b0;
        repeat (8) @(negedge CLK_1M);
        check("midstrobe_err", 32'(bus.ERR), 32'd0);

        // Init sequence then first data byte
        do_init();
        check("em_init_done", 32'(bus.INIT_DONE), 32'd0);
        wr(1'b1, 8'h41, 3'd0);
        check("ready_init_done", 32'(bus.INIT_DONE), 32'd1);
        rd_check(5'd0, 8'h41, "first");
        check("first_cursor", 32'(bus.CURSOR), 32'h01);
        check("first_err",    32'(bus.ERR),    32'd0);

        // Read transfer (clear code) is ignored entirely
        pulse_e(1'b0, 1'b1, 8'h01, 4);
        expect_cmd(1'b0, 3'd0, "rw_read");
        repeat (40) @(negedge CLK_1M);
        check("rw_cursor", 32'(bus.CURSOR), 32'h01);
        rd_check(5'd0, 8'h41, "rw");

        // DDRAM set to line 2
        wr(1'b0, 8'hC0, 3'd7);
        wr(1'b1, 8'h42, 3'd0);
        rd_check(5'd16, 8'h42, "line2");
        check("line2_cursor", 32'(bus.CURSOR), 32'h41);

        // Off-screen write at 0x27 then wrap to line 2
        wr(1'b0, 8'hA7, 3'd7);
        check("wrap_cursor0", 32'(bus.CURSOR), 32'h27);
        wr(1'b1, 8'h55, 3'd0);
        check("wrap_cursor1", 32'(bus.CURSOR), 32'h40);
        rd_check(5'd16, 8'h42, "offscreen");
        wr(1'b1, 8'h66, 3'd0);
        check("wrap_cursor2", 32'(bus.CURSOR), 32'h41);
        rd_check(5'd16, 8'h66, "wrap");
        check("wrap_err", 32'(bus.ERR), 32'd0);

        // Home and pulse-only commands
        wr(1'b0, 8'h02, 3'd2);
        check("home_cursor", 32'(bus.CURSOR), 32'h00);
        for (int i = 0; i < 16; i++) wr(1'b1, 8'h61 + 8'(i), 3'd0);
        check("fill_cursor", 32'(bus.CURSOR), 32'h10);
        rd_check(5'd5, 8'h66, "fill");
        wr(1'b0, 8'h10, 3'd5);
        wr(1'b0, 8'h08, 3'd4);
        wr(1'b0, 8'h20, 3'd6);
        wr(1'b0, 8'h40, 3'd7);
        check("pulse_only_cursor", 32'(bus.CURSOR), 32'h10);

        // Decrement mode, then clear with a strobe forced during CLEARING
        wr(1'b0, 8'h04, 3'd3);
        pulse_e(1'b0, 1'b0, 8'h01, 4);
        expect_cmd(1'b1, 3'd1, "clear");
        pulse_e(1'b0, 1'b0, 8'h3C, 2);
        expect_cmd(1'b0, 3'd0, "in_clear");
        check("clear_err",       32'(bus.ERR),       32'd1);
        check("clear_init_done", 32'(bus.INIT_DONE), 32'd1);
        repeat (20) @(negedge CLK_1M);
        for (int i = 0; i < 32; i++) rd_check(5'(i), 8'h20, "cleared");
        check("clear_cursor", 32'(bus.CURSOR), 32'h00);
        wr(1'b1, 8'h7A, 3'd0);
        check("clear_id_inc", 32'(bus.CURSOR), 32'h01);
        rd_check(5'd0, 8'h7A, "post_clear");

        // Decrementing writes from 0x00 wrap off-screen
        do_reset();
        do_init();
        wr(1'b0, 8'h04, 3'd3);
        check("dec_init_done", 32'(bus.INIT_DONE), 32'd1);
        wr(1'b1, 8'h31, 3'd0);
        check("dec_cursor0", 32'(bus.CURSOR), 32'h67);
        wr(1'b1, 8'h32, 3'd0);
        check("dec_cursor1", 32'(bus.CURSOR), 32'h66);
        wr(1'b1, 8'h33, 3'd0);
        check("dec_cursor2", 32'(bus.CURSOR), 32'h65);
        rd_check(5'd0,  8'h31, "dec");
        rd_check(5'd15, 8'h20, "dec");
        rd_check(5'd16, 8'h20, "dec");
        rd_check(5'd31, 8'h20, "dec");
        check("dec_err", 32'(bus.ERR), 32'd0);

        // DDRAM set validity
        wr(1'b0, 8'hE7, 3'd7);
        check("ddram_edge", 32'(bus.CURSOR), 32'h67);
        wr(1'b0, 8'hE8, 3'd7);
        check("ddram_bad_err",    32'(bus.ERR),    32'd1);
        check("ddram_bad_cursor", 32'(bus.CURSOR), 32'h67);

        // Stray instruction during init restarts the sequence
        do_reset();
        wr(1'b0, 8'h3C, 3'd6);
        wr(1'b0, 8'h0C, 3'd4);
        wr(1'b0, 8'h01, 3'd1);
        wr(1'b0, 8'h0C, 3'd4);
        wr(1'b0, 8'h06, 3'd3);
        wr(1'b1, 8'h50, 3'd0);
        check("restart_init_done", 32'(bus.INIT_DONE), 32'd0);
        check("restart_err",       32'(bus.ERR),       32'd1);
        rd_check(5'd0, 8'h20, "restart");

        repeat (4) @(negedge CLK_1M);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
